// File: rtl/common.sv
// Shared data-bus types: access size, byte strobes, and the request/response
// structures used between the memory stage and the data bus.
package common;

  typedef logic [63:0] word_t;
  typedef logic [63:0] addr_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/pipes.sv
// Pipeline register payloads around the memory stage and the memory-stage
// FSM state encoding.
package pipes;
  import common::*;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    word_t       aluout;
    word_t       writedata;
    msize_t      msize;
    logic        mem_unsigned;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    logic        regwrite;
    logic        memtoreg;
    word_t       aluout;
    word_t       memdata;
    logic        misalign;
  } memory_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mstate_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store strobe/data placement and
// load data alignment with zero/sign extension. Purely combinational.
module mem_align
  import common::*;
(
  input  msize_t      msize,
  input  logic        mem_unsigned,
  input  logic [2:0]  off,
  input  word_t       writedata,
  input  word_t       rdata,
  output strobe_t     strobe,
  output word_t       wdata,
  output word_t       rdata_ext
);

  logic [5:0] bit_off;
  word_t      raw;

  // Strobe pattern for an access at byte offset zero.
  function automatic strobe_t base_strobe(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Truncate the shifted-down load data to the access size and extend.
  function automatic word_t extend(word_t r, msize_t s, logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] sx;
    word_t              res;
    b = r[7:0];
    h = r[15:0];
    w = r[31:0];
    case (s)
      MSIZE1: begin
        sx  = 64'(b);
        res = uns ? 64'(r[7:0]) : word_t'(sx);
      end
      MSIZE2: begin
        sx  = 64'(h);
        res = uns ? 64'(r[15:0]) : word_t'(sx);
      end
      MSIZE4: begin
        sx  = 64'(w);
        res = uns ? 64'(r[31:0]) : word_t'(sx);
      end
      default: res = r;
    endcase
    return res;
  endfunction

  assign bit_off   = {off, 3'b000};
  assign raw       = rdata >> bit_off;
  assign strobe    = base_strobe(msize) << off;
  assign wdata     = writedata << bit_off;
  assign rdata_ext = extend(raw, msize, mem_unsigned);

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues load/store requests on the data bus, holds the
// pipeline until the access completes and hands the result to writeback.
// Non-memory instructions pass straight through in the same cycle.
module mem_access
  import common::*;
  import pipes::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int WORD_BYTES  = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  execute_data_t dataE,
  input  logic          flushM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM,
  output word_t         memdata_fwd
);

  mstate_t                         state, state_nxt;
  logic                            dropped, dropped_nxt;
  word_t                           memdata_p1, memdata_nxt;
  logic [$clog2(WORD_BYTES)-1:0]   off;
  logic                            mem_any;
  logic                            misalign;
  logic                            mem_op;
  strobe_t                         st_strobe;
  word_t                           st_wdata;
  word_t                           ld_data;
  word_t                           capture;
  logic                            req_on;

  assign off      = dataE.aluout[2:0];
  assign mem_any  = dataE.valid & (dataE.memread | dataE.memwrite);
  assign misalign = ALIGN_CHECK & mem_any & (|(dataE.aluout[2:0] & size_mask(dataE.msize)));
  assign mem_op   = mem_any & ~misalign;
  // Stores have no load result; keep the result register clean for them.
  assign capture  = dataE.memread ? ld_data : '0;

  mem_align u_align (
    .msize        (dataE.msize),
    .mem_unsigned (dataE.mem_unsigned),
    .off          (off),
    .writedata    (dataE.writedata),
    .rdata        (dresp.data),
    .strobe       (st_strobe),
    .wdata        (st_wdata),
    .rdata_ext    (ld_data)
  );

  // State, flush-drop flag and load result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dropped    <= 1'b0;
      memdata_p1 <= '0;
    end else begin
      state      <= state_nxt;
      dropped    <= dropped_nxt;
      memdata_p1 <= memdata_nxt;
    end
  end

  // Next state, bus request, stall and writeback payload.
  always_comb begin
    state_nxt   = state;
    dropped_nxt = dropped;
    memdata_nxt = memdata_p1;
    req_on      = 1'b0;
    stallM      = 1'b0;
    memdata_fwd = '0;

    dataM.valid     = dataE.valid & ~flushM;
    dataM.pc        = dataE.pc;
    dataM.raw_instr = dataE.raw_instr;
    dataM.dst       = dataE.dst;
    dataM.regwrite  = dataE.regwrite & ~misalign;
    dataM.memtoreg  = dataE.memtoreg;
    dataM.aluout    = dataE.aluout;
    dataM.memdata   = '0;
    dataM.misalign  = misalign;

    case (state)
      IDLE: begin
        if (mem_op) begin
          req_on      = 1'b1;
          stallM      = 1'b1;
          dataM.valid = 1'b0;
          dropped_nxt = flushM;
          if (dresp.addr_ok && dresp.data_ok) begin
            state_nxt   = DONE;
            memdata_nxt = capture;
          end else if (dresp.addr_ok) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        req_on      = 1'b1;
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (flushM) dropped_nxt = 1'b1;
        if (dresp.addr_ok && dresp.data_ok) begin
          state_nxt   = DONE;
          memdata_nxt = capture;
        end else if (dresp.addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (flushM) dropped_nxt = 1'b1;
        if (dresp.data_ok) begin
          state_nxt   = DONE;
          memdata_nxt = capture;
        end
      end
      DONE: begin
        dataM.valid   = dataE.valid & ~dropped & ~flushM;
        dataM.memdata = memdata_p1;
        memdata_fwd   = memdata_p1;
        dropped_nxt   = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    dreq = '0;
    if (req_on) begin
      dreq.valid  = 1'b1;
      dreq.addr   = dataE.aluout;
      dreq.size   = dataE.msize;
      dreq.strobe = dataE.memwrite ? st_strobe : '0;
      dreq.data   = dataE.memwrite ? st_wdata : '0;
    end

    // The request and stall must drop the moment reset asserts, even while
    // the upstream register still holds a memory instruction.
    if (!resetn) begin
      dreq        = '0;
      stallM      = 1'b0;
      dataM.valid = 1'b0;
    end
  end

endmodule
